wb_report_unit: RTL

WB_REPORT_UNIT -- requirements
Module: wb_report_unit

---
 rtl/wb_report_unit_pkg.sv | 29 ++
 rtl/wb_report_unit_sync_fifo.sv | 87 ++++++++
 rtl/wb_report_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_report_unit_pkg.sv
// rtl/wb_report_unit_pkg.sv - shared constants and helpers for the writeback report unit
//
// Purpose: register-range defaults, entry field widths and the capture filter
//          predicate shared by wb_report_unit and its bench.
// Ports:   none (package).

package wb_report_unit_pkg;

    // Width of a register index field in a reported entry.
    localparam int REG_IDX_W = 5;

    // Width of the core ID presented on to_peripheral.
    localparam int CORE_ID_W = 2;

    // Default reported register window (x10..x17, the argument registers).
    localparam int REG_LO_DEFAULT = 10;
    localparam int REG_HI_DEFAULT = 17;

    // True when a written register index falls inside the reported window.
    // x0 is never reported, even if the window were configured to include it.
    function automatic logic reg_in_range(
        input logic [REG_IDX_W-1:0] idx,
        input logic [REG_IDX_W-1:0] lo,
        input logic [REG_IDX_W-1:0] hi
    );
        return (idx != '0) && (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/wb_report_unit_sync_fifo.sv
// rtl/wb_report_unit_sync_fifo.sv - single-clock FIFO with full/empty/count status
//
// Purpose: DEPTH-entry first-in first-out buffer. Storage is unreset; pointers
//          and occupancy reset asynchronously. A push into a full FIFO is only
//          accepted when a pop happens in the same cycle.
// Ports:
//   clock  in   single clock
//   reset  in   asynchronous active-low reset
//   clear  in   synchronous flush, beats push and pop
//   push   in   write request
//   pop    in   read request (ignored while empty)
//   wdata  in   WIDTH data to write
//   rdata  out  WIDTH head entry (don't-care while empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  current occupancy

module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    assign do_pop  = pop & ~empty;
    // When full, the pop frees the head slot this edge, which is exactly the
    // slot wr_ptr addresses, so the write and the read never collide.
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 for free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/wb_report_unit.sv
// rtl/wb_report_unit.sv - captures writeback register writes into a report FIFO
//
// Purpose: filters register-file writes to a configured register window,
//          queues {reg, data} entries for a peripheral, and counts captures
//          lost to a full queue.
// Ports:
//   clock                in   single clock
//   reset                in   asynchronous active-low reset
//   enable               in   capture enable
//   clear                in   synchronous flush of FIFO, drop counter, overflow
//   write                in   writeback write strobe
//   write_reg            in   destination register index
//   write_data           in   written value
//   to_peripheral        out  constant core ID
//   to_peripheral_reg    out  head entry register index
//   to_peripheral_data   out  head entry value
//   to_peripheral_valid  out  head entry present
//   to_peripheral_ready  in   consumer takes the head entry
//   fifo_count           out  occupancy
//   overflow             out  sticky: a capture was dropped
//   drop_count           out  saturating count of dropped captures

module wb_report_unit
    import wb_report_unit_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int REG_LO     = REG_LO_DEFAULT,
    parameter int REG_HI     = REG_HI_DEFAULT,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     write,
    input  logic [REG_IDX_W-1:0]     write_reg,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [CORE_ID_W-1:0]     to_peripheral,
    output logic [REG_IDX_W-1:0]     to_peripheral_reg,
    output logic [DATA_WIDTH-1:0]    to_peripheral_data,
    output logic                     to_peripheral_valid,
    input  logic                     to_peripheral_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int ENTRY_W = REG_IDX_W + DATA_WIDTH;
    localparam logic [REG_IDX_W-1:0] LO = REG_IDX_W'(REG_LO);
    localparam logic [REG_IDX_W-1:0] HI = REG_IDX_W'(REG_HI);
    localparam logic [CNT_WIDTH-1:0] DROP_ONE = CNT_WIDTH'(1);

    logic               capture;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign to_peripheral = CORE_ID_W'(CORE);

    assign capture = enable & write & reg_in_range(write_reg, LO, HI);

    // Valid comes from the registered occupancy, so ready never reaches it.
    assign to_peripheral_valid = ~fifo_empty;
    assign pop  = to_peripheral_valid & to_peripheral_ready;
    assign drop = capture & fifo_full & ~pop;

    assign to_peripheral_reg  = head[ENTRY_W-1 -: REG_IDX_W];
    assign to_peripheral_data = head[DATA_WIDTH-1:0];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (capture),
        .pop   (pop),
        .wdata ({write_reg, write_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_ONE;
            end
        end
    end

endmodule
